tmr_scrub_ctrl: RTL and testbench

- Consumer stage placed directly downstream of a bank of triplicated flops (three copies A/B/C of one WIDTH-bit register).
- Every cycle it produces a registered, bitwise-majority-voted word.
- When the copies disagree, it issues a write-back strobe so the voted word is rewritten into all three copies (scrubbing), then waits a holdoff and rechecks.
- It counts corrections and flags a copy that stays stuck after repeated scrubs.

---
 rtl/tmr_scrub_ctrl.sv | 161 ++++++++++++++++
 tb/tb_tmr_scrub_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/tmr_scrub_ctrl.sv
// Majority voter and scrub controller for a triplicated register bank.
// Optional per-copy correction counters are enabled with TMR_SCRUB_COPYCNT_EN.
module tmr_scrub_ctrl #(
  parameter int WIDTH     = 8,
  parameter int HOLDOFF   = 2,
  parameter int RETRY_MAX = 3,
  parameter int CNT_W     = 8
) (
  input  logic             CLK,
  input  logic             R,
  input  logic             EN,
  input  logic             CLR,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] Q,
  output logic             WB,
  output logic [WIDTH-1:0] WD,
  output logic [2:0]       FCOPY,
  output logic [CNT_W-1:0] FAULT_CNT,
  output logic             STUCK
`ifdef TMR_SCRUB_COPYCNT_EN
  ,
  output logic [3:0]       CNT_A,
  output logic [3:0]       CNT_B,
  output logic [3:0]       CNT_C
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_CORRECT,
    ST_HOLD,
    ST_STUCK
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] q_reg;
  logic             mis_reg;
  logic [2:0]       dis_reg;
  logic             wb_reg;
  logic [2:0]       fcopy_reg;
  logic [CNT_W-1:0] fault_cnt_reg;
  logic             stuck_reg;
  logic [3:0]       retry_reg;
  logic [3:0]       hold_reg;
  logic [WIDTH-1:0] vote;

  always_comb begin
    vote = (A & B) | (B & C) | (A & C);
  end

  always_ff @(posedge CLK or posedge R) begin
    if (R) begin
      state_reg     <= ST_IDLE;
      q_reg         <= '0;
      mis_reg       <= 1'b0;
      dis_reg       <= '0;
      wb_reg        <= 1'b0;
      fcopy_reg     <= '0;
      fault_cnt_reg <= '0;
      stuck_reg     <= 1'b0;
      retry_reg     <= '0;
      hold_reg      <= '0;
    end else begin
      q_reg   <= vote;
      mis_reg <= (A != B) | (B != C);
      dis_reg <= {C != vote, B != vote, A != vote};
      wb_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (EN) state_reg <= ST_SCAN;
        end
        ST_SCAN: begin
          if (!EN) begin
            state_reg <= ST_IDLE;
          end else if (!mis_reg) begin
            retry_reg <= '0;
          end else if (retry_reg < 4'(RETRY_MAX)) begin
            state_reg <= ST_CORRECT;
            wb_reg    <= 1'b1;
            fcopy_reg <= fcopy_reg | dis_reg;
          end else if (!CLR) begin
            state_reg <= ST_STUCK;
            stuck_reg <= 1'b1;
          end
        end
        ST_CORRECT: begin
          if (!EN) begin
            state_reg <= ST_IDLE;
          end else begin
            state_reg <= ST_HOLD;
            hold_reg  <= 4'(HOLDOFF);
            retry_reg <= retry_reg + 4'd1;
            if (fault_cnt_reg != {CNT_W{1'b1}})
              fault_cnt_reg <= fault_cnt_reg + 1'b1;
          end
        end
        ST_HOLD: begin
          // Mismatches are ignored here: the bank needs time to settle after a write-back.
          if (!EN) begin
            state_reg <= ST_IDLE;
          end else if (hold_reg <= 4'd1) begin
            hold_reg  <= '0;
            state_reg <= ST_SCAN;
          end else begin
            hold_reg <= hold_reg - 4'd1;
          end
        end
        ST_STUCK: begin
          if (CLR) state_reg <= EN ? ST_SCAN : ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
      // Clear wins over any increment or sticky-bit update issued above.
      if (CLR) begin
        fault_cnt_reg <= '0;
        fcopy_reg     <= '0;
        retry_reg     <= '0;
        stuck_reg     <= 1'b0;
      end
    end
  end

  assign Q         = q_reg;
  assign WB        = wb_reg;
  assign WD        = q_reg;
  assign FCOPY     = fcopy_reg;
  assign FAULT_CNT = fault_cnt_reg;
  assign STUCK     = stuck_reg;

`ifdef TMR_SCRUB_COPYCNT_EN
  logic [2:0] dis_cap_reg;
  logic [3:0] copy_cnt_reg [3];

  // The last SCAN cycle's disagreement pattern is the one that caused the write-back.
  always_ff @(posedge CLK or posedge R) begin
    if (R) dis_cap_reg <= '0;
    else if (state_reg == ST_SCAN) dis_cap_reg <= dis_reg;
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_copy_cnt
      always_ff @(posedge CLK or posedge R) begin
        if (R)
          copy_cnt_reg[gi] <= '0;
        else if (CLR)
          copy_cnt_reg[gi] <= '0;
        else if (state_reg == ST_CORRECT && EN && dis_cap_reg[gi] && copy_cnt_reg[gi] != 4'hF)
          copy_cnt_reg[gi] <= copy_cnt_reg[gi] + 4'd1;
      end
    end
  endgenerate

  assign CNT_A = copy_cnt_reg[0];
  assign CNT_B = copy_cnt_reg[1];
  assign CNT_C = copy_cnt_reg[2];
`endif

endmodule

// File: tb/tb_tmr_scrub_ctrl.sv
// Directed bench for tmr_scrub_ctrl: a default instance and a CNT_W=2 instance share stimulus.
`timescale 1ns/1ps
module tb_tmr_scrub_ctrl;

  logic       CLK = 1'b0;
  logic       R   = 1'b1;
  logic       EN  = 1'b0;
  logic       CLR = 1'b0;
  logic [7:0] A   = 8'h00;
  logic [7:0] B   = 8'h00;
  logic [7:0] C   = 8'h00;

  logic [7:0] q, wd, q_s, wd_s;
  logic       wb, stuck, wb_s, stuck_s;
  logic [2:0] fcopy, fcopy_s;
  logic [7:0] fcnt;
  logic [1:0] fcnt_s;
`ifdef TMR_SCRUB_COPYCNT_EN
  logic [3:0] cnt_a, cnt_b, cnt_c, cnt_a_s, cnt_b_s, cnt_c_s;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  tmr_scrub_ctrl #(.WIDTH(8), .HOLDOFF(2), .RETRY_MAX(3), .CNT_W(8)) dut (
    .CLK(CLK), .R(R), .EN(EN), .CLR(CLR), .A(A), .B(B), .C(C),
    .Q(q), .WB(wb), .WD(wd), .FCOPY(fcopy), .FAULT_CNT(fcnt), .STUCK(stuck)
`ifdef TMR_SCRUB_COPYCNT_EN
    , .CNT_A(cnt_a), .CNT_B(cnt_b), .CNT_C(cnt_c)
`endif
  );

  tmr_scrub_ctrl #(.WIDTH(8), .HOLDOFF(2), .RETRY_MAX(3), .CNT_W(2)) dut_s (
    .CLK(CLK), .R(R), .EN(EN), .CLR(CLR), .A(A), .B(B), .C(C),
    .Q(q_s), .WB(wb_s), .WD(wd_s), .FCOPY(fcopy_s), .FAULT_CNT(fcnt_s), .STUCK(stuck_s)
`ifdef TMR_SCRUB_COPYCNT_EN
    , .CNT_A(cnt_a_s), .CNT_B(cnt_b_s), .CNT_C(cnt_c_s)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Wait (bounded) for a write-back strobe; a timeout counts as a failed check.
  task automatic wait_wb(input string tag);
    int n;
    n = 0;
    while (wb !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
    check(tag, {31'd0, wb}, 32'd1);
  endtask

  int wb_ticks[$];

  initial begin
    // Reset state
    #2;
    check("rst_q", {24'd0, q}, 32'h0);
    check("rst_wb", {31'd0, wb}, 32'h0);
    check("rst_stuck", {31'd0, stuck}, 32'h0);
    A = 8'h5A; B = 8'h5A; C = 8'h5A; EN = 1'b1;
    tick(); tick();
    check("rst_hold_q", {24'd0, q}, 32'h0);
    R = 1'b0;

    // Steady equal copies
    for (int i = 0; i < 10; i++) begin
      tick();
      check("steady_q", {24'd0, q}, 32'h5A);
      check("steady_wb", {31'd0, wb}, 32'h0);
    end
    check("steady_fcnt", {24'd0, fcnt}, 32'h0);
    check("steady_fcopy", {29'd0, fcopy}, 32'h0);

    // Single transient fault on C, rewritten by the write-back
    C = 8'h5B;
    tick();
    check("t2_q", {24'd0, q}, 32'h5A);
    check("t2_wb_early", {31'd0, wb}, 32'h0);
    tick();
    check("t2_wb", {31'd0, wb}, 32'h1);
    check("t2_wd", {24'd0, wd}, 32'h5A);
    check("t2_fcopy", {29'd0, fcopy}, 32'h4);
    C = 8'h5A;
    tick();
    check("t2_wb_drop", {31'd0, wb}, 32'h0);
    check("t2_fcnt", {24'd0, fcnt}, 32'h1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t2_no_wb", {31'd0, wb}, 32'h0);
      check("t2_q_hold", {24'd0, q}, 32'h5A);
    end

    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    check("clr_fcnt", {24'd0, fcnt}, 32'h0);

    // Permanent fault on C: three strobes HOLDOFF+2 apart, then STUCK
    C = 8'h5B;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (wb === 1'b1) wb_ticks.push_back(t);
    end
    check("t3_pulses", wb_ticks.size(), 32'd3);
    if (wb_ticks.size() == 3) begin
      check("t3_gap1", wb_ticks[1] - wb_ticks[0], 32'd4);
      check("t3_gap2", wb_ticks[2] - wb_ticks[1], 32'd4);
    end
    check("t3_stuck", {31'd0, stuck}, 32'h1);
    check("t3_fcnt", {24'd0, fcnt}, 32'h3);
    check("t3_fcnt_s", {30'd0, fcnt_s}, 32'h3);
    check("t3_fcopy", {29'd0, fcopy}, 32'h4);
`ifdef TMR_SCRUB_COPYCNT_EN
    check("t3_cnt_c", {28'd0, cnt_c}, 32'h3);
`endif

    // Clear out of STUCK
    C = 8'h5A;
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    check("t4_stuck", {31'd0, stuck}, 32'h0);
    check("t4_fcnt", {24'd0, fcnt}, 32'h0);
    check("t4_fcopy", {29'd0, fcopy}, 32'h0);
    check("t4_wb", {31'd0, wb}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t4_no_wb", {31'd0, wb}, 32'h0);
    end

    // Five separate faults on B: small counter saturates at 3
    for (int f = 0; f < 5; f++) begin
      B = 8'h4A;
      wait_wb("t5_wb_seen");
      check("t5_wd", {24'd0, wd}, 32'h5A);
      B = 8'h5A;
      repeat (5) tick();
    end
    check("t5_fcnt", {24'd0, fcnt}, 32'h5);
    check("t5_fcnt_s", {30'd0, fcnt_s}, 32'h3);
    check("t5_fcopy", {29'd0, fcopy}, 32'h2);
    check("t5_stuck", {31'd0, stuck}, 32'h0);
`ifdef TMR_SCRUB_COPYCNT_EN
    check("t5_cnt_b", {28'd0, cnt_b}, 32'h5);
    check("t5_cnt_a", {28'd0, cnt_a}, 32'h0);
`endif

    // Reset asserted during CORRECT aborts the strobe asynchronously
    A = 8'h5B;
    wait_wb("t6_wb_seen");
    #2;
    R = 1'b1;
    #1;
    check("t6_wb_async", {31'd0, wb}, 32'h0);
    check("t6_q", {24'd0, q}, 32'h0);
    check("t6_wd", {24'd0, wd}, 32'h0);
    check("t6_fcnt", {24'd0, fcnt}, 32'h0);
    check("t6_fcopy", {29'd0, fcopy}, 32'h0);
    check("t6_stuck", {31'd0, stuck}, 32'h0);
    A = 8'h5A;
    tick();
    R = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t6_no_wb", {31'd0, wb}, 32'h0);
    end
    check("t6_q_after", {24'd0, q}, 32'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
